// File: rtl/instr_mem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// LOADER_CHECKSUM_EN adds the trailing-checksum states.
package mips_16_loader_pkg;

  localparam int IMEM_WORD_WIDTH        = 16;
  localparam int LOADER_DEFAULT_TIMEOUT = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HI,
    ST_LO,
    ST_WRITE,
    ST_DONE,
    ST_ERR
`ifdef LOADER_CHECKSUM_EN
    , ST_CSUM_HI,
    ST_CSUM_LO
`endif
  } loader_state_e;

endpackage

// File: rtl/instr_mem_loader_byte_packer.sv
// Byte-pair capture for the loader: owns rx_ready and assembles {hi, lo} words.
// LOADER_CHECKSUM_EN exposes the unregistered word for the checksum compare.
module loader_byte_packer
  import mips_16_loader_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en_hi,
  input  logic                       en_lo,
  input  logic                       rx_valid,
  input  logic [7:0]                 rx_data,
  output logic                       rx_ready,
  output logic                       hi_xfer,
  output logic                       word_valid,
`ifdef LOADER_CHECKSUM_EN
  output logic [IMEM_WORD_WIDTH-1:0] word_next,
`endif
  output logic [IMEM_WORD_WIDTH-1:0] word_q
);

`ifndef LOADER_CHECKSUM_EN
  logic [IMEM_WORD_WIDTH-1:0] word_next;
`endif
  logic [7:0] hi_q;

  assign rx_ready   = en_hi | en_lo;
  assign hi_xfer    = en_hi & rx_valid;
  assign word_valid = en_lo & rx_valid;
  assign word_next  = {hi_q, rx_data};

  // word_q is what the WRITE cycle drives onto the memory bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q   <= '0;
      word_q <= '0;
    end else begin
      if (hi_xfer)    hi_q   <= rx_data;
      if (word_valid) word_q <= word_next;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Boot/reload controller: packs a byte stream into 16-bit words and writes imem from 0.
// LOADER_CHECKSUM_EN: a trailing 16-bit modular checksum must match before done.
module instr_mem_loader
  import mips_16_loader_pkg::*;
#(
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = LOADER_DEFAULT_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load_req,
  input  logic [ADDR_WIDTH:0]        load_len,
  input  logic                       rx_valid,
  input  logic [7:0]                 rx_data,
  output logic                       rx_ready,
  input  logic [ADDR_WIDTH-1:0]      fetch_pc,
  output logic [ADDR_WIDTH-1:0]      imem_addr,
  output logic                       imem_we,
  output logic [IMEM_WORD_WIDTH-1:0] imem_wdata,
  output logic                       cpu_stall,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_L = {1'b1, {ADDR_WIDTH{1'b0}}};

  loader_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0]      ptr_q;
  logic [ADDR_WIDTH:0]        len_q;
  logic [TW-1:0]              tmo_cnt;
  logic                       err_q;
  logic                       en_hi, en_lo, hi_xfer, word_valid, byte_xfer;
  logic                       len_ok, last_word, tmo_hit, start;
  logic [IMEM_WORD_WIDTH-1:0] word_q;
`ifdef LOADER_CHECKSUM_EN
  logic [IMEM_WORD_WIDTH-1:0] word_next, csum_q;
`endif

  loader_byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_hi      (en_hi),
    .en_lo      (en_lo),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .hi_xfer    (hi_xfer),
    .word_valid (word_valid),
`ifdef LOADER_CHECKSUM_EN
    .word_next  (word_next),
`endif
    .word_q     (word_q)
  );

`ifdef LOADER_CHECKSUM_EN
  assign en_hi = (state_q == ST_HI) || (state_q == ST_CSUM_HI);
  assign en_lo = (state_q == ST_LO) || (state_q == ST_CSUM_LO);
`else
  assign en_hi = (state_q == ST_HI);
  assign en_lo = (state_q == ST_LO);
`endif

  assign byte_xfer = hi_xfer | word_valid;
  assign len_ok    = (load_len != '0) && (load_len <= DEPTH_L);
  assign start     = (state_q == ST_IDLE) && load_req;
  // Length-based end detect, so a full-depth pointer wrap never matters
  assign last_word = ({1'b0, ptr_q} + 1'b1) == len_q;
  assign tmo_hit   = !byte_xfer && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (load_req && len_ok) state_d = ST_HI;
      ST_HI:    if (hi_xfer) state_d = ST_LO;
                else if (tmo_hit) state_d = ST_ERR;
      ST_LO:    if (word_valid) state_d = ST_WRITE;
                else if (tmo_hit) state_d = ST_ERR;
`ifdef LOADER_CHECKSUM_EN
      ST_WRITE: state_d = last_word ? ST_CSUM_HI : ST_HI;
      ST_CSUM_HI: if (hi_xfer) state_d = ST_CSUM_LO;
                  else if (tmo_hit) state_d = ST_ERR;
      ST_CSUM_LO: if (word_valid) state_d = (word_next == csum_q) ? ST_DONE : ST_ERR;
                  else if (tmo_hit) state_d = ST_ERR;
`else
      ST_WRITE: state_d = last_word ? ST_DONE : ST_HI;
`endif
      ST_DONE:  state_d = ST_IDLE;
      ST_ERR:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      len_q   <= '0;
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (start && len_ok) begin
        ptr_q <= '0;
        len_q <= load_len;
        err_q <= 1'b0;
      end else if (start || state_q == ST_ERR) begin
        err_q <= 1'b1;
      end
      if (state_q == ST_WRITE) ptr_q <= ptr_q + 1'b1;
      // Idle-gap counter only runs while waiting for a byte
      if (!(en_hi || en_lo) || byte_xfer) tmo_cnt <= '0;
      else                                tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  csum_q <= '0;
    else if (start)              csum_q <= '0;
    else if (state_q == ST_WRITE) csum_q <= csum_q + word_q;
  end
`endif

  assign busy       = (state_q != ST_IDLE);
  assign cpu_stall  = busy;
  assign imem_we    = (state_q == ST_WRITE);
  assign imem_wdata = word_q;
  assign imem_addr  = busy ? ptr_q : fetch_pc;
  assign done       = (state_q == ST_DONE);
  assign err        = err_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: random images and gaps scored against an array model.
module tb_instr_mem_loader;

  localparam int AW  = 4;
  localparam int TMO = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_req = 1'b0;
  logic [AW:0]   load_len = '0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_ready;
  logic [AW-1:0] fetch_pc = '0;
  logic [AW-1:0] imem_addr;
  logic          imem_we;
  logic [15:0]   imem_wdata;
  logic          cpu_stall, busy, done, err;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_xfer_cyc = 0;
  logic [15:0] img [16];
  int lo_cyc [16];
  logic [AW-1:0] wr_addr_q [$];
  logic [15:0]   wr_data_q [$];
  int            wr_cyc_q  [$];

  instr_mem_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .load_req(load_req), .load_len(load_len),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .fetch_pc(fetch_pc), .imem_addr(imem_addr), .imem_we(imem_we),
    .imem_wdata(imem_wdata), .cpu_stall(cpu_stall), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Write/done monitor; the loader must never offer rx_ready during a write
  always @(negedge clk) begin
    if (rst_n) begin
      if (imem_we) begin
        wr_addr_q.push_back(imem_addr);
        wr_data_q.push_back(imem_wdata);
        wr_cyc_q.push_back(cyc);
        tests++;
        if (rx_ready !== 1'b0) begin
          fails++;
          $display("FAIL rx_ready_in_write: got %b expected 0", rx_ready);
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_obs();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    done_cnt = 0;
  endtask

  task automatic start_load(input int len);
    load_req = 1'b1;
    load_len = (AW+1)'(len);
    @(negedge clk);
    load_req = 1'b0;
  endtask

  // Gap cycles may carry stray load_req pulses, which a busy loader must ignore
  task automatic send_byte(input logic [7:0] b, input int gap, input bit inj);
    bit r, ok;
    for (int g = 0; g < gap; g++) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      load_req = inj && ($urandom_range(0, 2) == 0);
      load_len = (AW+1)'($urandom_range(0, 31));
      @(negedge clk);
    end
    load_req = 1'b0;
    rx_valid = 1'b1;
    rx_data  = b;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      #1 r = rx_ready;
      @(negedge clk);
      if (r) begin ok = 1'b1; break; end
    end
    rx_valid = 1'b0;
    last_xfer_cyc = cyc;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL byte_accept: byte %h never accepted", b);
    end
  endtask

  task automatic do_load(input int len, input int gap_max, input bit inj, input bit bad_csum);
    logic [15:0] sum;
    int n;
    bit exp_done;
    clear_obs();
    start_load(len);
    tests++;
    if (cpu_stall !== 1'b1 || err !== 1'b0) begin
      fails++;
      $display("FAIL load_start: stall=%b err=%b expected stall=1 err=0", cpu_stall, err);
    end
    for (int i = 0; i < len; i++) begin
      send_byte(img[i][15:8], $urandom_range(0, gap_max), inj);
      send_byte(img[i][7:0],  $urandom_range(0, gap_max), inj);
      lo_cyc[i] = last_xfer_cyc;
    end
    exp_done = 1'b1;
`ifdef LOADER_CHECKSUM_EN
    sum = '0;
    for (int i = 0; i < len; i++) sum = sum + img[i];
    if (bad_csum) sum = sum + 16'd1;
    exp_done = !bad_csum;
    send_byte(sum[15:8], $urandom_range(0, gap_max), inj);
    send_byte(sum[7:0],  $urandom_range(0, gap_max), inj);
`else
    sum = '0;
`endif
    n = 0;
    while (busy && n < 40) begin @(negedge clk); n++; end
    tests++;
    if (busy !== 1'b0 || cpu_stall !== 1'b0) begin
      fails++;
      $display("FAIL load_finish: busy=%b stall=%b expected 0 0", busy, cpu_stall);
    end
    tests++;
    if (wr_addr_q.size() != len) begin
      fails++;
      $display("FAIL write_count: got %0d expected %0d", wr_addr_q.size(), len);
    end
    for (int i = 0; i < len && i < wr_addr_q.size(); i++) begin
      tests++;
      if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== img[i] || wr_cyc_q[i] != lo_cyc[i]) begin
        fails++;
        $display("FAIL write_%0d: got addr=%h data=%h cyc=%0d expected addr=%h data=%h cyc=%0d",
                 i, wr_addr_q[i], wr_data_q[i], wr_cyc_q[i], AW'(i), img[i], lo_cyc[i]);
      end
    end
    tests++;
    if (done_cnt != int'(exp_done) || err !== !exp_done) begin
      fails++;
      $display("FAIL load_result: done_cnt=%0d err=%b expected done_cnt=%0d err=%b",
               done_cnt, err, exp_done, !exp_done);
    end
`ifndef LOADER_CHECKSUM_EN
    if (wr_cyc_q.size() == len) begin
      tests++;
      if (done_cyc != wr_cyc_q[len-1] + 1) begin
        fails++;
        $display("FAIL done_timing: got cyc %0d expected %0d", done_cyc, wr_cyc_q[len-1] + 1);
      end
    end
`endif
  endtask

  task automatic test_reset();
    fetch_pc = AW'($urandom);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if ({busy, cpu_stall, done, err, imem_we, rx_ready} !== 6'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %b expected 000000", {busy, cpu_stall, done, err, imem_we, rx_ready});
    end
    tests++;
    if (imem_addr !== fetch_pc) begin
      fails++;
      $display("FAIL reset_addr: got %h expected %h", imem_addr, fetch_pc);
    end
    // A byte offered while idle is neither accepted nor written
    clear_obs();
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    fetch_pc = fetch_pc + 1'b1;
    #1;
    tests++;
    if (rx_ready !== 1'b0 || imem_addr !== fetch_pc) begin
      fails++;
      $display("FAIL idle_rx: rx_ready=%b addr=%h expected 0 %h", rx_ready, imem_addr, fetch_pc);
    end
    repeat (3) @(negedge clk);
    rx_valid = 1'b0;
    tests++;
    if (wr_addr_q.size() != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_rx_nowrite: writes=%0d busy=%b expected 0 0", wr_addr_q.size(), busy);
    end
  endtask

  task automatic test_basic();
    img[0] = 16'h9208; img[1] = 16'h9448; img[2] = 16'h9688;
    do_load(3, 0, 1'b0, 1'b0);
  endtask

  task automatic test_bad_len();
    int lens [3] = '{0, 17, 31};
    foreach (lens[k]) begin
      clear_obs();
      start_load(lens[k]);
      tests++;
      if (err !== 1'b1 || busy !== 1'b0) begin
        fails++;
        $display("FAIL bad_len_%0d: err=%b busy=%b expected 1 0", lens[k], err, busy);
      end
      repeat (3) @(negedge clk);
      tests++;
      if (wr_addr_q.size() != 0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL bad_len_nowrite_%0d: writes=%0d busy=%b expected 0 0", lens[k], wr_addr_q.size(), busy);
      end
    end
  endtask

  task automatic test_timeout();
    clear_obs();
    start_load(2);
    send_byte(8'h12, 0, 1'b0);
    // TMO idle cycles in LO lead to one ERR cycle, then IDLE with err set
    repeat (TMO - 1) @(negedge clk);
    tests++;
    if (busy !== 1'b1 || err !== 1'b0) begin
      fails++;
      $display("FAIL timeout_early: busy=%b err=%b expected 1 0", busy, err);
    end
    repeat (2) @(negedge clk);
    tests++;
    if (err !== 1'b1 || busy !== 1'b0 || cpu_stall !== 1'b0 || done_cnt != 0 || wr_addr_q.size() != 0) begin
      fails++;
      $display("FAIL timeout_err: err=%b busy=%b stall=%b done=%0d writes=%0d expected 1 0 0 0 0",
               err, busy, cpu_stall, done_cnt, wr_addr_q.size());
    end
    img[0] = 16'($urandom);
    do_load(1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int len;
    for (int it = 0; it < 8; it++) begin
      len = (it == 0) ? 16 : $urandom_range(1, 16);
      for (int i = 0; i < 16; i++) img[i] = 16'($urandom);
      do_load(len, 4, 1'b1, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 16; i++) img[i] = 16'($urandom);
    clear_obs();
    start_load(4);
    for (int i = 0; i < 2; i++) begin
      send_byte(img[i][15:8], 0, 1'b0);
      send_byte(img[i][7:0], 0, 1'b0);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, cpu_stall, done, err, imem_we, rx_ready} !== 6'b0 || imem_addr !== fetch_pc) begin
      fails++;
      $display("FAIL reset_mid: outs=%b addr=%h expected 000000 %h",
               {busy, cpu_stall, done, err, imem_we, rx_ready}, imem_addr, fetch_pc);
    end
    fetch_pc = fetch_pc + 3'd5;
    #1;
    tests++;
    if (imem_addr !== fetch_pc) begin
      fails++;
      $display("FAIL reset_mid_pc: got %h expected %h", imem_addr, fetch_pc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (wr_addr_q.size() != 2 || wr_data_q[0] !== img[0] || wr_data_q[1] !== img[1] || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_partial: writes=%0d busy=%b expected 2 writes busy=0",
               wr_addr_q.size(), busy);
    end
    do_load(2, 2, 1'b0, 1'b0);
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    img[0] = 16'h0001; img[1] = 16'h0002;
    do_load(2, 0, 1'b0, 1'b0);
    do_load(2, 0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) img[i] = 16'($urandom);
    do_load(9, 3, 1'b1, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_bad_len();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
